// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: debounced push-button driven LED pattern engine
module led_pattern_sequencer #(
    parameter int N_LEDS = 4,
    parameter int TICK_DIV = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key_n,
    output logic [N_LEDS-1:0] led,
    output logic [2:0]        mode,
    output logic              tick,
    output logic [3:0]        key_evt
);
    typedef enum logic [2:0] {ROTATE_L, ROTATE_R, PINGPONG, BLINK, ALL_ON, ALL_OFF} mode_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [N_LEDS-1:0] LSB = 1;
    localparam logic [N_LEDS-1:0] MSB = LSB << (N_LEDS - 1);
    logic [3:0] s1, s2, deb, deb_d;
    logic [PW-1:0] presc, nxt_presc;
    logic [N_LEDS-1:0] nxt_led;
    logic dir_dn, nxt_dir_dn, entry;
    mode_t st, nxt;
    assign mode = st;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
            deb_d <= '1;
            key_evt <= '0;
        end else begin
            s1 <= key_n;
            s2 <= s1;
            deb_d <= deb;
            key_evt <= deb_d & ~deb;
        end
    // any sample matching the accepted state restarts the stability count
    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [DW-1:0] cnt;
        logic d;
        assign deb[i] = d;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                cnt <= '0;
                d <= 1'b1;
            end else if (s2[i] == d) cnt <= '0;
            else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                d <= s2[i];
            end else cnt <= cnt + 1'b1;
    end
    always_comb begin
        entry = |key_evt;
        nxt = st;
        if (key_evt[3]) nxt = ROTATE_L;
        else if (key_evt[2]) nxt = ALL_ON;
        else if (key_evt[1]) nxt = ALL_OFF;
        else if (key_evt[0]) nxt = st == ROTATE_R ? PINGPONG : st == PINGPONG ? BLINK : ROTATE_R;
        nxt_presc = (entry || presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
        nxt_dir_dn = dir_dn;
        nxt_led = led;
        if (entry) begin
            nxt_dir_dn = 1'b0;
            nxt_led = nxt == ROTATE_R ? MSB : nxt == ALL_OFF ? '0 : nxt inside {BLINK, ALL_ON} ? '1 : LSB;
        end else if (tick) begin
            case (st)
                ROTATE_L: nxt_led = {led[N_LEDS-2:0], led[N_LEDS-1]};
                ROTATE_R: nxt_led = {led[0], led[N_LEDS-1:1]};
                PINGPONG: begin
                    nxt_dir_dn = dir_dn ? !led[0] : led[N_LEDS-1];
                    nxt_led = nxt_dir_dn ? led >> 1 : led << 1;
                end
                BLINK: nxt_led = ~led;
                default: nxt_led = led;
            endcase
        end
    end
    // tick is registered from the next count so it is high while the count sits at TICK_DIV-1
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st <= ALL_OFF;
            led <= '0;
            presc <= '0;
            tick <= 1'b0;
            dir_dn <= 1'b0;
        end else begin
            st <= nxt;
            led <= nxt_led;
            presc <= nxt_presc;
            tick <= nxt_presc == PW'(TICK_DIV - 1);
            dir_dn <= nxt_dir_dn;
        end
endmodule
